// File: rtl/sr_cmd_debounce_if.sv
// ---------------------------------------------------------------------------
// sr_cmd_debounce_if
// Bundles the button inputs and the command/level outputs of the SR command
// debouncer.
//   set_btn, reset_btn : raw push-button levels (asynchronous, may bounce)
//   set, reset         : one-cycle commands to the downstream SR latch
//   set_lvl, reset_lvl : debounced button levels
//   collision          : one-cycle flag, both channels qualified on one edge
// Modports:
//   master : button side, drives the raw buttons and observes the outputs
//   slave  : the debouncer itself
// ---------------------------------------------------------------------------
interface sr_cmd_debounce_if;
    logic set_btn;
    logic reset_btn;
    logic set;
    logic reset;
    logic set_lvl;
    logic reset_lvl;
    logic collision;

    modport master (
        output set_btn, reset_btn,
        input  set, reset, set_lvl, reset_lvl, collision
    );

    modport slave (
        input  set_btn, reset_btn,
        output set, reset, set_lvl, reset_lvl, collision
    );
endinterface

// File: rtl/sr_cmd_debounce.sv
// ---------------------------------------------------------------------------
// sr_cmd_debounce
// Command stage in front of an SR latch. Each raw button is synchronised by
// two flops, debounced by a four-state FSM with a stability counter, and each
// qualified press becomes a single-cycle set or reset command. set and reset
// are never high together, so the latch never sees S=R=1.
//
// Parameters:
//   DEB_CYCLES : consecutive equal synchronised samples to accept a change (>=1)
//   CNT_W      : debounce counter width, 2**CNT_W-1 must be >= DEB_CYCLES
// Ports:
//   clk   : single clock, all state on posedge
//   rst_n : synchronous active-low reset
//   bus   : sr_cmd_debounce_if.slave (buttons in, commands/levels out)
// Build option:
//   SR_CMD_RESET_PRIO_EN defined   -> on collision reset=1, set=0
//   SR_CMD_RESET_PRIO_EN undefined -> on collision both commands dropped
// ---------------------------------------------------------------------------
module sr_cmd_debounce #(
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = 8
) (
    input logic               clk,
    input logic               rst_n,
    sr_cmd_debounce_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RISE_CHK = 2'd1,
        HIGH     = 2'd2,
        FALL_CHK = 2'd3
    } deb_state_e;

    localparam logic [CNT_W-1:0] DEB_LIM = CNT_W'(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    if (DEB_CYCLES < 1) begin : g_bad_deb
        $error("sr_cmd_debounce: DEB_CYCLES must be >= 1");
    end
    if (((longint'(1) << CNT_W) - 1) < longint'(DEB_CYCLES)) begin : g_bad_cnt_w
        $error("sr_cmd_debounce: CNT_W too narrow for DEB_CYCLES");
    end

    logic [1:0] btn;
    logic [1:0] s1;
    logic [1:0] s2;
    logic [1:0] rise;
    logic [1:0] lvl;

    // Channel 0 is set, channel 1 is reset.
    assign btn = {bus.reset_btn, bus.set_btn};

    // NOTE: every flop, synchroniser included, takes the synchronous reset so a
    // press in progress is fully discarded and restarts with full latency.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            // NOTE: non-blocking assignments make s2 take the old s1, forming a
            // true two-stage synchroniser instead of collapsing to one flop.
            s1 <= btn;
            s2 <= s1;
        end
    end

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        deb_state_e       state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             rise_c;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        // The counter holds the number of consecutive samples that disagree
        // with the accepted level; it is below DEB_LIM in every check state,
        // so the increment can never wrap.
        always_comb begin
            // NOTE: defaults first so every path assigns every output and no
            // latch is inferred.
            state_d = state_q;
            cnt_d   = cnt_q;
            rise_c  = 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (s2[ch]) begin
                        if (DEB_LIM == CNT_ONE) begin
                            state_d = HIGH;
                            cnt_d   = '0;
                            rise_c  = 1'b1;
                        end else begin
                            state_d = RISE_CHK;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                RISE_CHK: begin
                    if (!s2[ch]) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q + CNT_ONE == DEB_LIM) begin
                        state_d = HIGH;
                        cnt_d   = '0;
                        rise_c  = 1'b1;
                    end else begin
                        cnt_d   = cnt_q + CNT_ONE;
                    end
                end
                HIGH: begin
                    if (!s2[ch]) begin
                        if (DEB_LIM == CNT_ONE) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else begin
                            state_d = FALL_CHK;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                FALL_CHK: begin
                    if (s2[ch]) begin
                        state_d = HIGH;
                        cnt_d   = '0;
                    end else if (cnt_q + CNT_ONE == DEB_LIM) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        assign rise[ch] = rise_c;
        assign lvl[ch]  = (state_q == HIGH) || (state_q == FALL_CHK);
    end

    // Command register: a lone qualified rise fires its own pulse; a
    // simultaneous pair raises collision and never lets set and reset
    // coexist.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.set       <= 1'b0;
            bus.reset     <= 1'b0;
            bus.collision <= 1'b0;
        end else begin
            bus.collision <= rise[0] & rise[1];
            bus.set       <= rise[0] & ~rise[1];
`ifdef SR_CMD_RESET_PRIO_EN
            bus.reset     <= rise[1];
`else
            bus.reset     <= rise[1] & ~rise[0];
`endif
        end
    end

    assign bus.set_lvl   = lvl[0];
    assign bus.reset_lvl = lvl[1];

endmodule

// File: tb/tb_sr_cmd_debounce.sv
// ---------------------------------------------------------------------------
// tb_sr_cmd_debounce
// Drives sr_cmd_debounce through directed button scenarios and a randomized
// bouncing phase. The expected behaviour comes from a reference model that
// delays each button by two samples and flips a channel's level once
// DEB_CYCLES consecutive samples disagree with it.
// ---------------------------------------------------------------------------
module tb_sr_cmd_debounce;
    localparam int DEB = 4;

    logic clk = 1'b0;
    logic rst_n;

    always #2 clk = ~clk;

    sr_cmd_debounce_if bus ();

    sr_cmd_debounce #(
        .DEB_CYCLES (DEB),
        .CNT_W      (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    logic [1:0] m_s1, m_s2, m_lvl;
    int         m_run [2];
    logic       m_set, m_reset, m_coll;

    task automatic check(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic sb, input logic rb);
        logic [1:0] fsm_in;
        logic [1:0] rose;
        if (!r) begin
            m_s1 = '0; m_s2 = '0; m_lvl = '0;
            m_run[0] = 0; m_run[1] = 0;
            m_set = 1'b0; m_reset = 1'b0; m_coll = 1'b0;
        end else begin
            fsm_in = m_s2;
            m_s2   = m_s1;
            m_s1   = {rb, sb};
            rose   = '0;
            for (int ch = 0; ch < 2; ch++) begin
                if (fsm_in[ch] != m_lvl[ch]) begin
                    m_run[ch]++;
                    if (m_run[ch] >= DEB) begin
                        m_lvl[ch] = ~m_lvl[ch];
                        m_run[ch] = 0;
                        rose[ch]  = m_lvl[ch];
                    end
                end else begin
                    m_run[ch] = 0;
                end
            end
            m_coll = rose[0] & rose[1];
            m_set  = rose[0] & ~rose[1];
`ifdef SR_CMD_RESET_PRIO_EN
            m_reset = rose[1];
`else
            m_reset = rose[1] & ~rose[0];
`endif
        end
    endtask

    // One clock: drive, take the edge, advance the model, compare mid-cycle.
    task automatic step(input logic r, input logic sb, input logic rb);
        rst_n         = r;
        bus.set_btn   = sb;
        bus.reset_btn = rb;
        @(posedge clk);
        #1;
        model_edge(r, sb, rb);
        check("set",       bus.set,       m_set);
        check("reset",     bus.reset,     m_reset);
        check("collision", bus.collision, m_coll);
        check("set_lvl",   bus.set_lvl,   m_lvl[0]);
        check("reset_lvl", bus.reset_lvl, m_lvl[1]);
        check("exclusive", bus.set & bus.reset, 1'b0);
    endtask

    initial begin
        int np, pidx, nr, nl, nc, lidx;
        logic [4:0] bounce;
        logic sb, rb;
        int   sb_left, rb_left;

        rst_n = 1'b0; bus.set_btn = 1'b0; bus.reset_btn = 1'b0;

        // 1. reset with buttons idle
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0);

        // 2. clean press and release of set
        np = 0; pidx = -1;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 1'b0);
            if (bus.set) begin np++; pidx = i; end
        end
        check_int("t2_press_pulses", np, 1);
        check_int("t2_press_edge", pidx, DEB + 1);
        np = 0; lidx = -1;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (bus.set) np++;
            if (!bus.set_lvl && lidx < 0) lidx = i;
        end
        check_int("t2_release_pulses", np, 0);
        check_int("t2_release_edge", lidx, DEB + 1);

        // 3. short reset glitch
        nr = 0; nl = 0;
        for (int i = 0; i < 15; i++) begin
            step(1'b1, 1'b0, (i < 3));
            if (bus.reset) nr++;
            if (bus.reset_lvl) nl++;
        end
        check_int("t3_glitch_pulses", nr, 0);
        check_int("t3_glitch_level", nl, 0);

        // 4. bounce then steady press
        bounce = 5'b01101;
        np = 0; pidx = -1;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, bounce[i], 1'b0);
            if (bus.set) np++;
        end
        for (int i = 0; i < 15; i++) begin
            step(1'b1, 1'b1, 1'b0);
            if (bus.set) begin np++; pidx = i; end
        end
        check_int("t4_bounce_pulses", np, 1);
        check_int("t4_bounce_edge", pidx, DEB + 1);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0);

        // 5. simultaneous press
        np = 0; nr = 0; nc = 0; pidx = -1;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b1, 1'b1);
            if (bus.set) np++;
            if (bus.reset) nr++;
            if (bus.collision) begin nc++; pidx = i; end
        end
        check_int("t5_collision_cnt", nc, 1);
        check_int("t5_collision_edge", pidx, DEB + 1);
        check_int("t5_set_cnt", np, 0);
`ifdef SR_CMD_RESET_PRIO_EN
        check_int("t5_reset_cnt", nr, 1);
`else
        check_int("t5_reset_cnt", nr, 0);
`endif
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0);

        // 6. reset mid-count, button still held afterwards
        np = 0; pidx = -1;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 1'b0);
            if (bus.set) np++;
        end
        step(1'b0, 1'b1, 1'b0);
        check_int("t6_pre_reset_pulses", np, 0);
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b1, 1'b0);
            if (bus.set) begin np++; pidx = i; end
        end
        check_int("t6_post_reset_pulses", np, 1);
        check_int("t6_post_reset_edge", pidx, DEB + 1);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0);

        // Randomized bouncing on both channels with occasional resets and
        // forced simultaneous presses.
        sb = 1'b0; rb = 1'b0; sb_left = 0; rb_left = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                sb = 1'b1; rb = 1'b1;
                sb_left = 2 * DEB; rb_left = 2 * DEB;
            end
            if (sb_left == 0) begin
                sb = 1'($urandom_range(0, 1));
                sb_left = $urandom_range(1, 2 * DEB);
            end
            if (rb_left == 0) begin
                rb = 1'($urandom_range(0, 1));
                rb_left = $urandom_range(1, 2 * DEB);
            end
            step(($urandom_range(0, 63) != 0), sb, rb);
            sb_left--;
            rb_left--;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
